ctrl_pipe: RTL and testbench

Pipelined successor to the single-cycle `controller`. It decodes the instruction in the Decode stage and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It resolves branches in Execute from the ALU flags (all six RV32I conditions) and generates load-use stall and branch/jump flush controls. It sits between the Decode-stage instruction fields and the 5-stage datapath, and reuses `maindec` and `aludec` internally for the combinational decode.

---
 rtl/ctrl_pipe.sv | 375 +++++++++++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- pipelined control unit for the 5-stage RV32I core.
//
// The Decode-stage instruction fields are decoded by maindec/aludec. The
// control bundle is then carried through the ID/EX, EX/MEM and MEM/WB
// registers. Branches and jumps are resolved in Execute from the ALU flags.
// Load-use stalls and the branch/jump flushes are generated here.
//
// Optional feature: define CTRL_MEXT_EN to decode the RV32M multiply/divide
// group (opcode 0110011, funct7 = 0000001). In the default build
// MulDivE/MulOpE are tied to 0 and funct7b0D is ignored.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   opD, funct3D, funct7b5D,
//   funct7b0D                Decode-stage instruction fields
//   Rs1D, Rs2D, RdD          Decode-stage register specifiers
//   stall_i                  external freeze (memory wait)
//   ZeroE/NegE/OvfE/CarryE   Execute-stage ALU flags from the subtract
//   ImmSrcD                  immediate format select (combinational)
//   RegWrite/ResultSrc/MemWrite/Rd {E,M,W}   per-stage control bundle
//   ALUSrcE, ALUControlE     Execute-stage ALU controls
//   PCSrcE                   taken branch or jump
//   StallF/StallD/FlushD/FlushE   hazard controls
//   IllegalE                 unknown opcode in Execute
//   MulDivE, MulOpE          M-extension op in Execute
//
// ALU operation encoding on ALUControlE[3:0]:
//   0000 add  0001 sub  0010 and  0011 or   0100 xor
//   0101 slt  0110 sll  0111 srl  1000 sra  1001 sltu  1010 pass B (lui)

// Main decoder: opcode -> datapath control. Unknown opcodes give all-zero
// control with legal_o = 0.
module maindec (
    input  logic [6:0] op_i,
    output logic       regWrite_o,
    output logic [1:0] resultSrc_o,
    output logic       memWrite_o,
    output logic       jump_o,
    output logic       branch_o,
    output logic       aluSrc_o,
    output logic [2:0] immSrc_o,
    output logic [1:0] aluOp_o,
    output logic       legal_o
);

    // One opcode per arm. ALUOp: 00 add, 01 sub, 10 by funct, 11 pass B.
    always_comb begin
        regWrite_o  = 1'b0;
        resultSrc_o = 2'b00;
        memWrite_o  = 1'b0;
        jump_o      = 1'b0;
        branch_o    = 1'b0;
        aluSrc_o    = 1'b0;
        immSrc_o    = 3'b000;
        aluOp_o     = 2'b00;
        legal_o     = 1'b1;
        case (op_i)
            7'b0000011: begin // load
                regWrite_o  = 1'b1;
                resultSrc_o = 2'b01;
                aluSrc_o    = 1'b1;
            end
            7'b0100011: begin // store
                memWrite_o = 1'b1;
                aluSrc_o   = 1'b1;
                immSrc_o   = 3'b001;
            end
            7'b0110011: begin // R-type
                regWrite_o = 1'b1;
                aluOp_o    = 2'b10;
            end
            7'b0010011: begin // I-type ALU
                regWrite_o = 1'b1;
                aluSrc_o   = 1'b1;
                aluOp_o    = 2'b10;
            end
            7'b1100011: begin // branch
                branch_o = 1'b1;
                immSrc_o = 3'b010;
                aluOp_o  = 2'b01;
            end
            7'b1101111: begin // jal
                regWrite_o  = 1'b1;
                resultSrc_o = 2'b10;
                jump_o      = 1'b1;
                immSrc_o    = 3'b011;
            end
            7'b1100111: begin // jalr: ALU forms rs1 + imm for the target
                regWrite_o  = 1'b1;
                resultSrc_o = 2'b10;
                jump_o      = 1'b1;
                aluSrc_o    = 1'b1;
            end
            7'b0110111: begin // lui
                regWrite_o = 1'b1;
                aluSrc_o   = 1'b1;
                immSrc_o   = 3'b100;
                aluOp_o    = 2'b11;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// ALU decoder: ALUOp plus funct fields -> ALU operation.
module aludec (
    input  logic       opb5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] aluOp_i,
    output logic [3:0] aluControl_o
);

    // funct7b5 selects sub only for R-type (opb5 = 1). For addi the same
    // bit belongs to the immediate.
    always_comb begin
        aluControl_o = 4'b0000;
        case (aluOp_i)
            2'b00: aluControl_o = 4'b0000;
            2'b01: aluControl_o = 4'b0001;
            2'b11: aluControl_o = 4'b1010;
            default: begin
                case (funct3_i)
                    3'b000:  aluControl_o = (funct7b5_i & opb5_i) ? 4'b0001 : 4'b0000;
                    3'b001:  aluControl_o = 4'b0110;
                    3'b010:  aluControl_o = 4'b0101;
                    3'b011:  aluControl_o = 4'b1001;
                    3'b100:  aluControl_o = 4'b0100;
                    3'b101:  aluControl_o = funct7b5_i ? 4'b1000 : 4'b0111;
                    3'b110:  aluControl_o = 4'b0011;
                    default: aluControl_o = 4'b0010;
                endcase
            end
        endcase
    end

endmodule

// ALUC_W must be at least 4. Bits above [3:0] of ALUControlE are zero.
module ctrl_pipe #(
    parameter int unsigned ALUC_W       = 4,
    parameter int unsigned ILLEGAL_TRAP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        opD,
    input  logic [2:0]        funct3D,
    input  logic              funct7b5D,
    input  logic              funct7b0D,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic              stall_i,
    input  logic              ZeroE,
    input  logic              NegE,
    input  logic              OvfE,
    input  logic              CarryE,
    output logic [2:0]        ImmSrcD,
    output logic              RegWriteE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcE,
    output logic [1:0]        ResultSrcM,
    output logic [1:0]        ResultSrcW,
    output logic              MemWriteE,
    output logic              MemWriteM,
    output logic              ALUSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              PCSrcE,
    output logic [4:0]        RdE,
    output logic [4:0]        RdM,
    output logic [4:0]        RdW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              IllegalE,
    output logic              MulDivE,
    output logic [2:0]        MulOpE
);

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       jump;
        logic       branch;
        logic       aluSrc;
        logic [3:0] aluControl;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic       illegal;
`ifdef CTRL_MEXT_EN
        logic       mulDiv;
        logic [2:0] mulOp;
`endif
    } exCtrl_t;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic [4:0] rd;
    } memCtrl_t;

    typedef struct packed {
        logic       regWrite;
        logic [1:0] resultSrc;
        logic [4:0] rd;
    } wbCtrl_t;

    logic       mdRegWrite;
    logic [1:0] mdResultSrc;
    logic       mdMemWrite;
    logic       mdJump;
    logic       mdBranch;
    logic       mdAluSrc;
    logic [1:0] mdAluOp;
    logic       mdLegal;
    logic [3:0] aluCtrlD;

    exCtrl_t  decD;
    exCtrl_t  eCtrl_d, eCtrl_q;
    memCtrl_t mCtrl_q;
    wbCtrl_t  wCtrl_q;

    logic branchCond;
    logic lwStall;

    maindec uMaindec (
        .op_i        (opD),
        .regWrite_o  (mdRegWrite),
        .resultSrc_o (mdResultSrc),
        .memWrite_o  (mdMemWrite),
        .jump_o      (mdJump),
        .branch_o    (mdBranch),
        .aluSrc_o    (mdAluSrc),
        .immSrc_o    (ImmSrcD),
        .aluOp_o     (mdAluOp),
        .legal_o     (mdLegal)
    );

    aludec uAludec (
        .opb5_i       (opD[5]),
        .funct3_i     (funct3D),
        .funct7b5_i   (funct7b5D),
        .aluOp_i      (mdAluOp),
        .aluControl_o (aluCtrlD)
    );

`ifndef CTRL_MEXT_EN
    logic unusedFunct7b0;
    assign unusedFunct7b0 = funct7b0D;
`endif

    // Assemble the Decode-stage bundle. An unknown opcode becomes a bubble
    // with its destination cleared, optionally flagged as illegal.
    always_comb begin
        decD            = '0;
        decD.regWrite   = mdRegWrite;
        decD.resultSrc  = mdResultSrc;
        decD.memWrite   = mdMemWrite;
        decD.jump       = mdJump;
        decD.branch     = mdBranch;
        decD.aluSrc     = mdAluSrc;
        decD.aluControl = aluCtrlD;
        decD.funct3     = funct3D;
        decD.rd         = RdD;
        if (!mdLegal) begin
            decD         = '0;
            decD.illegal = (ILLEGAL_TRAP != 0);
        end
`ifdef CTRL_MEXT_EN
        // The M group shares the R-type opcode. It writes the register file
        // through the ALU-result path but leaves the ALU idle.
        if (mdLegal && (opD == 7'b0110011) && funct7b0D && !funct7b5D) begin
            decD.mulDiv     = 1'b1;
            decD.mulOp      = funct3D;
            decD.aluControl = 4'b0000;
        end
`endif
    end

    // Branch condition from the Execute flags. The signed conditions use
    // N^V, and the unsigned conditions use the subtract carry (C=1 means no borrow).
    always_comb begin
        branchCond = 1'b0;
        case (eCtrl_q.funct3)
            3'b000:  branchCond = ZeroE;
            3'b001:  branchCond = !ZeroE;
            3'b100:  branchCond = NegE ^ OvfE;
            3'b101:  branchCond = !(NegE ^ OvfE);
            3'b110:  branchCond = !CarryE;
            3'b111:  branchCond = CarryE;
            default: branchCond = 1'b0;
        endcase
    end

    assign PCSrcE  = (eCtrl_q.branch & branchCond) | eCtrl_q.jump;

    assign lwStall = (eCtrl_q.resultSrc == 2'b01) & eCtrl_q.regWrite
                   & (eCtrl_q.rd != 5'd0)
                   & ((eCtrl_q.rd == Rs1D) | (eCtrl_q.rd == Rs2D));

    // An external freeze suppresses the flushes, so the frozen stages keep
    // their contents. The flush still wins over a load-use stall, because
    // the stalled Decode instruction is on the wrong path.
    assign StallF = lwStall | stall_i;
    assign StallD = lwStall | stall_i;
    assign FlushD = PCSrcE & !stall_i;
    assign FlushE = (lwStall | PCSrcE) & !stall_i;

    // ID/EX next state: hold on freeze, bubble on flush, else take Decode.
    always_comb begin
        eCtrl_d = eCtrl_q;
        if (!stall_i) begin
            if (FlushE) begin
                eCtrl_d = '0;
            end else begin
                eCtrl_d = decD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eCtrl_q <= '0;
        end else begin
            eCtrl_q <= eCtrl_d;
        end
    end

    // EX/MEM and MEM/WB have no flush. They only freeze with stall_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCtrl_q <= '0;
            wCtrl_q <= '0;
        end else if (!stall_i) begin
            mCtrl_q.regWrite  <= eCtrl_q.regWrite;
            mCtrl_q.resultSrc <= eCtrl_q.resultSrc;
            mCtrl_q.memWrite  <= eCtrl_q.memWrite;
            mCtrl_q.rd        <= eCtrl_q.rd;
            wCtrl_q.regWrite  <= mCtrl_q.regWrite;
            wCtrl_q.resultSrc <= mCtrl_q.resultSrc;
            wCtrl_q.rd        <= mCtrl_q.rd;
        end
    end

    assign RegWriteE   = eCtrl_q.regWrite;
    assign ResultSrcE  = eCtrl_q.resultSrc;
    assign MemWriteE   = eCtrl_q.memWrite;
    assign ALUSrcE     = eCtrl_q.aluSrc;
    assign ALUControlE = ALUC_W'(eCtrl_q.aluControl);
    assign RdE         = eCtrl_q.rd;
    assign IllegalE    = eCtrl_q.illegal;

    assign RegWriteM   = mCtrl_q.regWrite;
    assign ResultSrcM  = mCtrl_q.resultSrc;
    assign MemWriteM   = mCtrl_q.memWrite;
    assign RdM         = mCtrl_q.rd;

    assign RegWriteW   = wCtrl_q.regWrite;
    assign ResultSrcW  = wCtrl_q.resultSrc;
    assign RdW         = wCtrl_q.rd;

`ifdef CTRL_MEXT_EN
    assign MulDivE = eCtrl_q.mulDiv;
    assign MulOpE  = eCtrl_q.mulOp;
`else
    assign MulDivE = 1'b0;
    assign MulOpE  = 3'b000;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- directed-vector bench for ctrl_pipe.
//
// Instruction fields are driven 1 time unit after each rising edge. Outputs
// are sampled on the falling edge. Expected values are hand-computed constants.
module tb_ctrl_pipe;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RT   = 7'b0110011;
    localparam logic [6:0] OP_IT   = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opD;
    logic [2:0] funct3D;
    logic       funct7b5D, funct7b0D;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       stall_i;
    logic       ZeroE, NegE, OvfE, CarryE;
    logic [2:0] ImmSrcD;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
    logic       MemWriteE, MemWriteM;
    logic       ALUSrcE;
    logic [3:0] ALUControlE;
    logic       PCSrcE;
    logic [4:0] RdE, RdM, RdW;
    logic       StallF, StallD, FlushD, FlushE;
    logic       IllegalE, MulDivE;
    logic [2:0] MulOpE;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    ctrl_pipe #(.ALUC_W(4), .ILLEGAL_TRAP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D), .funct7b0D(funct7b0D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .stall_i(stall_i),
        .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
        .ImmSrcD(ImmSrcD),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .IllegalE(IllegalE), .MulDivE(MulDivE), .MulOpE(MulOpE)
    );

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives the Decode-stage instruction fields.
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                                 input logic f7b0, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd);
        opD = op; funct3D = f3; funct7b5D = f7b5; funct7b0D = f7b0;
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
    endtask

    task automatic idle();
        applyStimulus(OP_IT, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic setFlags(input logic z, input logic n, input logic v, input logic c);
        ZeroE = z; NegE = n; OvfE = v; CarryE = c;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Decodes one instruction, then leaves it in E and stops at the sample point.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                         input logic f7b0, input logic [4:0] rd);
        applyStimulus(op, f3, f7b5, f7b0, 5'd1, 5'd2, rd);
        nextCycle();
        idle();
        @(negedge clk);
    endtask

    logic [2:0] brF3 [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
    logic       expZ [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       expNC[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0;
        setFlags(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd4);

        // Reset state
        @(negedge clk);
        checkOutput("rst ImmSrcD sw", ImmSrcD, 3'b001);
        checkOutput("rst RegWriteE", RegWriteE, 0);
        checkOutput("rst RegWriteM", RegWriteM, 0);
        checkOutput("rst RegWriteW", RegWriteW, 0);
        checkOutput("rst PCSrcE", PCSrcE, 0);
        checkOutput("rst StallF", StallF, 0);
        checkOutput("rst FlushE", FlushE, 0);
        checkOutput("rst FlushD", FlushD, 0);
        nextCycle();
        rst_n = 1'b1;

        // Mid-stream asynchronous reset
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
        nextCycle();
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        nextCycle();
        idle();
        checkOutput("pre-rst RdE", RdE, 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst RegWriteE", RegWriteE, 0);
        checkOutput("async rst ResultSrcE", ResultSrcE, 0);
        checkOutput("async rst RegWriteM", RegWriteM, 0);
        checkOutput("async rst RdM", RdM, 0);
        nextCycle();
        rst_n = 1'b1;

        // add x3,x1,x2 through E, M, W
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        checkOutput("add ImmSrcD", ImmSrcD, 3'b000);
        checkOutput("post-rst RegWriteE", RegWriteE, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("add RegWriteE", RegWriteE, 1);
        checkOutput("add ALUControlE", ALUControlE, 4'b0000);
        checkOutput("add RdE", RdE, 3);
        checkOutput("add ALUSrcE", ALUSrcE, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("add RegWriteM", RegWriteM, 1);
        checkOutput("add RdM", RdM, 3);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("add RegWriteW", RegWriteW, 1);
        checkOutput("add RdW", RdW, 3);
        nextCycle();

        // lw x5,0(x1) ; add x6,x5,x2 -> one stall cycle
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        nextCycle();
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd5, 5'd2, 5'd6);
        @(negedge clk);
        checkOutput("lwuse StallF", StallF, 1);
        checkOutput("lwuse StallD", StallD, 1);
        checkOutput("lwuse FlushE", FlushE, 1);
        checkOutput("lwuse FlushD", FlushD, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("lwuse bubble RegWriteE", RegWriteE, 0);
        checkOutput("lwuse bubble RdE", RdE, 0);
        checkOutput("lwuse StallF released", StallF, 0);
        checkOutput("lwuse ResultSrcM", ResultSrcM, 2'b01);
        checkOutput("lwuse RdM", RdM, 5);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("lwuse add RdE", RdE, 6);
        checkOutput("lwuse add RegWriteE", RegWriteE, 1);
        checkOutput("lwuse RegWriteM bubble", RegWriteM, 0);
        checkOutput("lwuse RdW", RdW, 5);
        checkOutput("lwuse ResultSrcW", ResultSrcW, 2'b01);
        nextCycle();

        // lw x0 then a use of x0 -> no stall
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd0);
        nextCycle();
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd0, 5'd2, 5'd6);
        @(negedge clk);
        checkOutput("lw x0 StallF", StallF, 0);
        checkOutput("lw x0 FlushE", FlushE, 0);
        nextCycle();

        // Load-use through rs2
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        nextCycle();
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd1, 5'd5, 5'd6);
        @(negedge clk);
        checkOutput("lwuse rs2 StallD", StallD, 1);
        nextCycle();
        idle();
        nextCycle();

        // Branch sweep, two flag patterns
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 7; i++) begin
                if (pass == 0) setFlags(1'b1, 1'b0, 1'b0, 1'b0);
                else           setFlags(1'b0, 1'b1, 1'b0, 1'b1);
                applyStimulus(OP_BR, brF3[i], 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
                @(negedge clk);
                if (i == 0) checkOutput("br ImmSrcD", ImmSrcD, 3'b010);
                nextCycle();
                idle();
                @(negedge clk);
                checkOutput($sformatf("br p%0d f3=%0b PCSrcE", pass, brF3[i]), PCSrcE,
                            (pass == 0) ? expZ[i] : expNC[i]);
                checkOutput($sformatf("br p%0d f3=%0b FlushD", pass, brF3[i]), FlushD,
                            (pass == 0) ? expZ[i] : expNC[i]);
                checkOutput($sformatf("br p%0d f3=%0b FlushE", pass, brF3[i]), FlushE,
                            (pass == 0) ? expZ[i] : expNC[i]);
                nextCycle();
            end
        end
        setFlags(1'b0, 1'b0, 1'b0, 1'b0);

        // jal x1 ; add x2,x1,x1
        applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1);
        @(negedge clk);
        checkOutput("jal ImmSrcD", ImmSrcD, 3'b011);
        nextCycle();
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd1, 5'd1, 5'd2);
        @(negedge clk);
        checkOutput("jal PCSrcE", PCSrcE, 1);
        checkOutput("jal ResultSrcE", ResultSrcE, 2'b10);
        checkOutput("jal RdE", RdE, 1);
        checkOutput("jal FlushD", FlushD, 1);
        checkOutput("jal FlushE", FlushE, 1);
        checkOutput("jal StallF", StallF, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("jal flushed RegWriteE", RegWriteE, 0);
        checkOutput("jal flushed RdE", RdE, 0);
        checkOutput("jal ResultSrcM", ResultSrcM, 2'b10);
        checkOutput("jal RdM", RdM, 1);
        nextCycle();

        issue(OP_JALR, 3'b000, 1'b0, 1'b0, 5'd1);
        checkOutput("jalr PCSrcE", PCSrcE, 1);
        checkOutput("jalr ALUSrcE", ALUSrcE, 1);
        checkOutput("jalr ResultSrcE", ResultSrcE, 2'b10);
        nextCycle();
        idle();
        nextCycle();

        // stall_i for 3 cycles across lw ; add
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd7);
        nextCycle();
        applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5);
        nextCycle();
        applyStimulus(OP_RT, 3'b000, 1'b0, 1'b0, 5'd5, 5'd2, 5'd6);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d StallF", i), StallF, 1);
            checkOutput($sformatf("stall%0d FlushE", i), FlushE, 0);
            checkOutput($sformatf("stall%0d FlushD", i), FlushD, 0);
            checkOutput($sformatf("stall%0d RdE", i), RdE, 5);
            checkOutput($sformatf("stall%0d ResultSrcE", i), ResultSrcE, 2'b01);
            checkOutput($sformatf("stall%0d RdM", i), RdM, 7);
            nextCycle();
        end
        stall_i = 1'b0;
        @(negedge clk);
        checkOutput("unstall FlushE", FlushE, 1);
        checkOutput("unstall StallF", StallF, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("unstall bubble RdE", RdE, 0);
        checkOutput("unstall RdM", RdM, 5);
        checkOutput("unstall RdW", RdW, 7);
        checkOutput("unstall StallF low", StallF, 0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("unstall add RdE", RdE, 6);
        checkOutput("unstall RdM bubble", RdM, 0);
        checkOutput("unstall RdW lw", RdW, 5);
        nextCycle();

        // Taken branch held by stall_i: no flush until released
        setFlags(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_BR, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
        nextCycle();
        idle();
        stall_i = 1'b1;
        @(negedge clk);
        checkOutput("br+stall PCSrcE", PCSrcE, 1);
        checkOutput("br+stall FlushD", FlushD, 0);
        checkOutput("br+stall FlushE", FlushE, 0);
        nextCycle();
        stall_i = 1'b0;
        @(negedge clk);
        checkOutput("br unstall FlushD", FlushD, 1);
        nextCycle();
        setFlags(1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal opcode
        issue(OP_BAD, 3'b000, 1'b0, 1'b0, 5'd9);
        checkOutput("illegal IllegalE", IllegalE, 1);
        checkOutput("illegal RegWriteE", RegWriteE, 0);
        checkOutput("illegal MemWriteE", MemWriteE, 0);
        checkOutput("illegal RdE", RdE, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("illegal one cycle", IllegalE, 0);
        checkOutput("illegal RegWriteM", RegWriteM, 0);
        nextCycle();

        // Illegal opcode behind a taken branch is flushed
        setFlags(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(OP_BR, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
        nextCycle();
        applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd9);
        @(negedge clk);
        checkOutput("illegal+br PCSrcE", PCSrcE, 1);
        nextCycle();
        idle();
        setFlags(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("illegal flushed", IllegalE, 0);
        nextCycle();

        // ALU decode and other formats
        issue(OP_RT, 3'b000, 1'b1, 1'b0, 5'd4);
        checkOutput("sub ALUControlE", ALUControlE, 4'b0001);
        nextCycle();
        issue(OP_IT, 3'b000, 1'b1, 1'b0, 5'd4);
        checkOutput("addi ALUControlE", ALUControlE, 4'b0000);
        checkOutput("addi ALUSrcE", ALUSrcE, 1);
        nextCycle();
        issue(OP_IT, 3'b101, 1'b1, 1'b0, 5'd4);
        checkOutput("srai ALUControlE", ALUControlE, 4'b1000);
        nextCycle();
        issue(OP_RT, 3'b011, 1'b0, 1'b0, 5'd4);
        checkOutput("sltu ALUControlE", ALUControlE, 4'b1001);
        nextCycle();
        issue(OP_SW, 3'b010, 1'b0, 1'b0, 5'd4);
        checkOutput("sw MemWriteE", MemWriteE, 1);
        checkOutput("sw RegWriteE", RegWriteE, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("sw MemWriteM", MemWriteM, 1);
        nextCycle();
        applyStimulus(OP_LUI, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 5'd8);
        @(negedge clk);
        checkOutput("lui ImmSrcD", ImmSrcD, 3'b100);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("lui ALUControlE", ALUControlE, 4'b1010);
        checkOutput("lui RegWriteE", RegWriteE, 1);
        nextCycle();

`ifdef CTRL_MEXT_EN
        issue(OP_RT, 3'b000, 1'b0, 1'b1, 5'd10);
        checkOutput("mul MulDivE", MulDivE, 1);
        checkOutput("mul MulOpE", MulOpE, 3'b000);
        checkOutput("mul ALUControlE", ALUControlE, 4'b0000);
        checkOutput("mul RegWriteE", RegWriteE, 1);
        checkOutput("mul ResultSrcE", ResultSrcE, 2'b00);
        nextCycle();
        issue(OP_RT, 3'b100, 1'b0, 1'b1, 5'd10);
        checkOutput("div MulOpE", MulOpE, 3'b100);
        checkOutput("div ALUControlE", ALUControlE, 4'b0000);
        nextCycle();
`else
        issue(OP_RT, 3'b100, 1'b0, 1'b1, 5'd10);
        checkOutput("noM MulDivE", MulDivE, 0);
        checkOutput("noM MulOpE", MulOpE, 3'b000);
        checkOutput("noM ALUControlE xor", ALUControlE, 4'b0100);
        checkOutput("noM RegWriteE", RegWriteE, 1);
        nextCycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
